// File: rtl/bitplane_serializer_16x4.sv
// Bit-plane serializer: M operands of N bits each in, one M-bit plane per cycle
// out, LSB plane first, with a single-entry pending buffer for back-to-back frames.
module bitplane_serializer_16x4 #(
  parameter int M = 16,
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M*N-1:0]  in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [M-1:0]    data_bits,
  output logic            plane_valid,
  output logic            plane_first,
  output logic            plane_last,
  output logic [IW-1:0]   plane_idx,
  output logic            busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic [IW-1:0]    cnt;
  logic [M*N-1:0]   shreg;
  logic [M*N-1:0]   pend;
  logic             pend_full;

  logic             accept;
  logic             load_slot;
  logic             do_load;
  logic [M*N-1:0]   load_frame;
  logic [IW-1:0]    nxt;

  // Operand 0 lands on the MSB lane of the plane.
  function automatic logic [M-1:0] plane_of(
    input logic [M*N-1:0] f,
    input logic [IW-1:0]  i
  );
    logic [M-1:0] b;
    logic [N-1:0] op;
    b = '0;
    for (int k = 0; k < M; k++) begin
      op = f[N*k +: N];
      b[M-1-k] = op[i];
    end
    return b;
  endfunction

  assign in_ready  = !pend_full && !rst;
  assign accept    = in_valid && in_ready;
  assign load_slot = (state == IDLE) || (cnt == LAST);
  assign nxt       = cnt + 1'b1;
  assign plane_idx = cnt;
  assign busy      = plane_valid || pend_full;

  always_comb begin
    do_load    = load_slot && (pend_full || accept);
    load_frame = pend_full ? pend : in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      data_bits   <= '0;
      plane_valid <= 1'b0;
      plane_first <= 1'b0;
      plane_last  <= 1'b0;
    end else if (load_slot) begin
      if (do_load) begin
        state       <= SHIFT;
        cnt         <= '0;
        shreg       <= load_frame;
        data_bits   <= plane_of(load_frame, '0);
        plane_valid <= 1'b1;
        plane_first <= 1'b1;
        plane_last  <= (N == 1);
        pend_full   <= 1'b0;
      end else begin
        state       <= IDLE;
        cnt         <= '0;
        data_bits   <= '0;
        plane_valid <= 1'b0;
        plane_first <= 1'b0;
        plane_last  <= 1'b0;
      end
    end else begin
      cnt         <= nxt;
      data_bits   <= plane_of(shreg, nxt);
      plane_first <= 1'b0;
      plane_last  <= (nxt == LAST);
      if (accept) begin
        pend      <= in_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitplane_serializer_16x4.sv
// Bench for bitplane_serializer_16x4: frame-queue model checked every
// cycle, plus directed scenarios with literal plane expectations.
module tb_bitplane_serializer_16x4;

  localparam int M = 16;
  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   data_bits;
  logic          plane_valid;
  logic          plane_first;
  logic          plane_last;
  logic [1:0]    plane_idx;
  logic          busy;

  int tests = 0;
  int fails = 0;

  bitplane_serializer_16x4 #(.M(M), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_bits(data_bits),
    .plane_valid(plane_valid),
    .plane_first(plane_first),
    .plane_last(plane_last),
    .plane_idx(plane_idx),
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] plane_of(
    input logic [63:0] f,
    input int i
  );
    logic [15:0] b;
    b = '0;
    for (int k = 0; k < M; k++)
      b[M-1-k] = f[N*k + i];
    return b;
  endfunction

  // Frame-level model: what is shifting out, and what waits behind it.
  logic [63:0] pq [$];
  logic [63:0] cur_f;
  bit          cur_v = 0;
  int          cur_p = 0;
  bit          armed = 0;

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && !rst && (pq.size() == 0);
    if (rst) begin
      pq.delete();
      cur_v = 0;
      cur_p = 0;
    end else if (!cur_v || cur_p == N-1) begin
      if (pq.size() != 0) begin
        cur_f = pq.pop_front();
        cur_v = 1;
        cur_p = 0;
      end else if (acc) begin
        cur_f = in_data;
        cur_v = 1;
        cur_p = 0;
      end else begin
        cur_v = 0;
        cur_p = 0;
      end
    end else begin
      cur_p++;
      if (acc) pq.push_back(in_data);
    end
    armed = 1;
  end

  always @(negedge clk) begin
    logic [15:0] ed;
    if (armed) begin
      ed = cur_v ? plane_of(cur_f, cur_p) : 16'h0;
      chk("m_data", data_bits, ed);
      chk("m_valid", plane_valid, cur_v);
      chk("m_first", plane_first, cur_v && cur_p == 0);
      chk("m_last", plane_last, cur_v && cur_p == N-1);
      chk("m_idx", plane_idx, cur_v ? cur_p : 0);
      chk("m_busy", busy, cur_v || pq.size() != 0);
      chk("m_ready", in_ready, !rst && pq.size() == 0);
    end
  end

  task tick();
    @(posedge clk);
    #2;
  endtask

  task send(input logic [63:0] f);
    bit go;
    bit done;
    done = 0;
    in_valid = 1;
    in_data = f;
    for (int t = 0; t < 40 && !done; t++) begin
      go = in_ready;
      tick();
      done = go;
    end
    in_valid = 0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task expect_planes(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c, input logic [15:0] d);
    logic [15:0] p [4];
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_data", data_bits, p[i]);
      chk("lit_idx", plane_idx, i);
      chk("lit_first", plane_first, i == 0);
      chk("lit_last", plane_last, i == 3);
      chk("lit_valid", plane_valid, 1);
    end
  endtask

  task settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  localparam logic [63:0] F32 = 64'h1764_3212_1764_3212;
  localparam logic [63:0] FFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] F9  = 64'h0000_0000_0000_0009;
  localparam logic [63:0] FC  = 64'h0123_4567_89AB_CDEF;

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    in_valid = 0;
    in_data = '0;
    settle(3);
    @(negedge clk);
    chk("rst_valid", plane_valid, 0);
    chk("rst_data", data_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    tick();

    send(F32);
    expect_planes(16'h5353, 16'hB6B6, 16'h0E0E, 16'h0000);
    settle(3);

    send(FFF);
    expect_planes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    settle(2);
    send(F9);
    expect_planes(16'h8000, 16'h0000, 16'h0000, 16'h8000);
    settle(3);

    send(FFF);
    fork
      send(F9);
      begin
        expect_planes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        expect_planes(16'h8000, 16'h0000, 16'h0000, 16'h8000);
      end
    join
    settle(3);

    send(F32);
    send(FFF);
    send(FC);
    send(F9);
    settle(20);

    send(F32);
    send(FC);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("abort_valid", plane_valid, 0);
    chk("abort_data", data_bits, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    settle(6);
    send(F32);
    expect_planes(16'h5353, 16'hB6B6, 16'h0E0E, 16'h0000);
    settle(3);

    in_data = FFF;
    in_valid = 1;
    rst = 1;
    tick();
    rst = 0;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drop_valid", plane_valid, 0);
    end
    settle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitplane_serializer_16x4.md
BITPLANE_SERIALIZER_16X4 -- requirements
Module: bitplane_serializer_16x4

Interface
REQ-001 Parameter M, default 16, number of operand lanes (bit-plane width).
REQ-002 Parameter N, default 4, operand width (planes per frame).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  M*N  frame of M operands; operand k at in_data[N*k+N-1:N*k].
REQ-006 in_valid  input  1  in_data holds a frame.
REQ-007 in_ready  output  1  block can accept a frame this cycle.
REQ-008 data_bits  output  M  current bit-plane for downstream parallel adder.
REQ-009 plane_valid  output  1  data_bits holds a valid plane.
REQ-010 plane_first  output  1  current plane is plane 0 (LSB) of a frame.
REQ-011 plane_last  output  1  current plane is plane N-1 (MSB) of a frame.
REQ-012 plane_idx  output  clog2(N)  index of the current plane.
REQ-013 busy  output  1  a frame is being emitted or one is pending.

Function
REQ-014 Handshake: frame accepted on a rising edge where in_valid and in_ready are both 1; in_data is not sampled at any other time.
REQ-015 Plane i of operand set: data_bits[M-1-k] = bit i of operand k (operand 0 on MSB lane).
REQ-016 Planes emitted LSB first, one per cycle, N consecutive cycles per frame; outputs registered, no downstream backpressure.
REQ-017 FSM states IDLE (plane_valid=0) and SHIFT (plane_valid=1); internal plane counter 0..N-1 drives plane_idx.
REQ-018 Load event: from IDLE, or in SHIFT with counter=N-1; loads frame into shift register, presents plane 0, counter=0, state SHIFT.
REQ-019 Load source priority: pending buffer if full (buffer then cleared), else accepted input frame (bypass), else no load.
REQ-020 In SHIFT at counter=N-1 with no load source: state to IDLE, plane_valid=0 next cycle.
REQ-021 Latency: frame accepted while IDLE or on a counter=N-1 edge with pending empty presents plane 0 in the cycle immediately after the accepting edge.
REQ-022 Frame accepted in SHIFT with counter<N-1 is stored in the single-entry pending buffer.
REQ-023 in_ready = !pending_full && !rst; at most two frames held (one shifting, one pending).
REQ-024 Back-to-back frames: plane 0 of next frame follows plane N-1 of previous with no bubble.
REQ-025 plane_first = plane_valid && counter==0; plane_last = plane_valid && counter==N-1.
REQ-026 busy = plane_valid || pending_full.
REQ-027 When plane_valid=0, data_bits=0 and plane_idx=0.

Reset
REQ-028 rst asserted on an edge: state IDLE, counter 0, pending cleared, shift register 0, data_bits=0, plane_valid/first/last=0, plane_idx=0, busy=0.
REQ-029 in_ready=0 while rst is high; in_ready=1 in first cycle after rst deasserts.
REQ-030 rst mid-frame aborts the frame and discards the pending frame; no remaining planes emitted.
REQ-031 rst wins over a simultaneous handshake; that frame is dropped.

Verification
REQ-032 Operands k0..k15 = 2,1,2,3,4,6,7,1,2,1,2,3,4,6,7,1, accepted from IDLE -> next 4 cycles data_bits 0x5353, 0xB6B6, 0x0E0E, 0x0000; plane_idx 0..3; first on cycle 1, last on cycle 4.
REQ-033 All operands 0xF -> four planes 0xFFFF; operand 0 = 0x9, others 0 -> 0x8000, 0x0000, 0x0000, 0x8000.
REQ-034 Frame A accepted, frame B offered next cycle -> B pending, in_ready=0 until A's plane-3 edge, B plane 0 directly after A plane 3, in_ready=1 again.
REQ-035 Frame C held with in_valid=1 while pending full -> not accepted until in_ready=1; C data emitted intact, no frame lost or duplicated.
REQ-036 rst pulsed during plane 1 with a frame pending -> next cycle all outputs 0; no further planes; new frame after rst emits normally.
REQ-037 in_valid=1 with in_ready=1 on the same edge as rst=1 -> frame dropped; plane_valid stays 0.
